microsequencer_ctrl: RTL and testbench

- Microprogram sequencer for the ARM control unit.
- Each cycle it computes the next microstore address from the CU fields held in the control register, the instruction decoder's entry address, and status inputs (MOC, condition result).
- It drives the microstore ROM address and the control register load enable.
- It includes a small return stack for microsubroutines and stalls on memory-operation handshakes.

---
 rtl/microseq_pkg.sv | 25 ++
 rtl/microsequencer_ctrl_if.sv | 40 ++++
 rtl/microseq_return_stack.sv | 55 +++++
 rtl/microsequencer_ctrl.sv | 144 ++++++++++++++
 tb/tb_microsequencer_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/microseq_pkg.sv
// Shared encodings for the microprogram sequencer.
// Optional wait timeout is enabled by defining MICROSEQ_WAIT_TIMEOUT_EN.
package microseq_pkg;

    localparam int MS_ADDR_W = 8;

    typedef enum logic [2:0] {
        NS_NEXT   = 3'b000,
        NS_JUMP   = 3'b001,
        NS_CJUMP  = 3'b010,
        NS_DECODE = 3'b011,
        NS_WAIT   = 3'b100,
        NS_CALL   = 3'b101,
        NS_RET    = 3'b110,
        NS_RST    = 3'b111
    } ns_sel_e;

    typedef enum logic [1:0] {
        CS_MOC  = 2'b00,
        CS_COND = 2'b01,
        CS_ONE  = 2'b10,
        CS_IRQ  = 2'b11
    } cond_sel_e;

endpackage

// File: rtl/microsequencer_ctrl_if.sv
// Control-register fields, status inputs and sequencer outputs.
// wait_timeout exists only when MICROSEQ_WAIT_TIMEOUT_EN is defined.
interface microsequencer_ctrl_if
    import microseq_pkg::*;
#(
    parameter int ADDR_W = MS_ADDR_W
);
    logic [2:0]        ns_sel;
    logic [1:0]        cond_sel;
    logic              inv;
    logic [ADDR_W-1:0] cr_addr;
    logic [ADDR_W-1:0] dec_addr;
    logic              moc;
    logic              cond_true;
    logic              irq;
    logic [ADDR_W-1:0] state_addr;
    logic              cr_load;
    logic              stall;
    logic              stack_err;
`ifdef MICROSEQ_WAIT_TIMEOUT_EN
    logic              wait_timeout;
`endif

    modport master (
        output ns_sel, cond_sel, inv, cr_addr, dec_addr, moc, cond_true, irq,
`ifdef MICROSEQ_WAIT_TIMEOUT_EN
        input  wait_timeout,
`endif
        input  state_addr, cr_load, stall, stack_err
    );

    modport slave (
        input  ns_sel, cond_sel, inv, cr_addr, dec_addr, moc, cond_true, irq,
`ifdef MICROSEQ_WAIT_TIMEOUT_EN
        output wait_timeout,
`endif
        output state_addr, cr_load, stall, stack_err
    );

endinterface

// File: rtl/microseq_return_stack.sv
// LIFO of return microaddresses; a push when full drops the oldest entry.
module microseq_return_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              err_pulse
);
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [CNT_W-1:0]  count;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(STACK_DEPTH));
    assign err_pulse = (push && full) || (pop && empty);

    // Entry count-1 is the top of stack.
    always_comb begin
        dout = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (CNT_W'(i + 1) == count) dout = mem[i];
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (push) begin
            if (full) begin
                for (int i = 0; i < STACK_DEPTH - 1; i++) mem[i] <= mem[i + 1];
                mem[STACK_DEPTH - 1] <= din;
            end else begin
                for (int i = 0; i < STACK_DEPTH; i++) begin
                    if (CNT_W'(i) == count) mem[i] <= din;
                end
                count <= count + 1'b1;
            end
        end else if (pop && !empty) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/microsequencer_ctrl.sv
// Microprogram sequencer: next microaddress selection, return stack, WAIT stall.
// Define MICROSEQ_WAIT_TIMEOUT_EN to bound WAIT stalls and branch to FAULT_VEC.
module microsequencer_ctrl
    import microseq_pkg::*;
#(
    parameter int                ADDR_W      = MS_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
    parameter int                STACK_DEPTH = 2
`ifdef MICROSEQ_WAIT_TIMEOUT_EN
    ,
    parameter int                WAIT_TIMEOUT = 255,
    parameter logic [ADDR_W-1:0] FAULT_VEC    = {ADDR_W{1'b1}}
`endif
) (
    input  logic                 CLK,
    input  logic                 RESET,
    microsequencer_ctrl_if.slave bus
);
    logic [ADDR_W-1:0] state_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] inc_addr;
    logic [ADDR_W-1:0] stk_dout;
    logic              first;
    logic              stack_err;
    logic              test;
    logic              sel;
    logic              raw_stall;
    logic              stall_int;
    logic              stk_push;
    logic              stk_pop;
    logic              stk_clear;
    logic              stk_empty;
    logic              stk_full;
    logic              stk_err_pulse;

`ifdef MICROSEQ_WAIT_TIMEOUT_EN
    localparam int WCNT_W = ($clog2(WAIT_TIMEOUT + 1) > 8) ? $clog2(WAIT_TIMEOUT + 1) : 8;
    logic [WCNT_W-1:0] wait_cnt;
    logic              timeout_hit;
    logic              wait_timeout;
`endif

    assign inc_addr = state_addr + 1'b1;

    always_comb begin
        case (cond_sel_e'(bus.cond_sel))
            CS_MOC:  sel = bus.moc;
            CS_COND: sel = bus.cond_true;
            CS_ONE:  sel = 1'b1;
            CS_IRQ:  sel = bus.irq;
            default: sel = 1'b1;
        endcase
        test      = sel ^ bus.inv;
        raw_stall = (ns_sel_e'(bus.ns_sel) == NS_WAIT) && !test;
`ifdef MICROSEQ_WAIT_TIMEOUT_EN
        timeout_hit = raw_stall && (wait_cnt == WCNT_W'(WAIT_TIMEOUT));
        stall_int   = raw_stall && !timeout_hit;
`else
        stall_int   = raw_stall;
`endif
    end

    always_comb begin
        next_addr = state_addr;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_clear = 1'b0;
        case (ns_sel_e'(bus.ns_sel))
            NS_NEXT:   next_addr = inc_addr;
            NS_JUMP:   next_addr = bus.cr_addr;
            NS_CJUMP:  next_addr = test ? bus.cr_addr : inc_addr;
            NS_DECODE: next_addr = bus.dec_addr;
            NS_WAIT:   next_addr = test ? inc_addr : state_addr;
            NS_CALL: begin
                stk_push  = 1'b1;
                next_addr = bus.cr_addr;
            end
            NS_RET: begin
                stk_pop   = 1'b1;
                next_addr = stk_empty ? RESET_VEC : stk_dout;
            end
            NS_RST: begin
                stk_clear = 1'b1;
                next_addr = RESET_VEC;
            end
            default: next_addr = state_addr;
        endcase
`ifdef MICROSEQ_WAIT_TIMEOUT_EN
        if (timeout_hit) next_addr = FAULT_VEC;
`endif
    end

    microseq_return_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .CLK       (CLK),
        .RESET     (RESET),
        .clear     (stk_clear),
        .push      (stk_push),
        .pop       (stk_pop),
        .din       (inc_addr),
        .dout      (stk_dout),
        .empty     (stk_empty),
        .full      (stk_full),
        .err_pulse (stk_err_pulse)
    );

    // first masks cr_load while the control register still holds stale data.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_addr <= RESET_VEC;
            first      <= 1'b1;
            stack_err  <= 1'b0;
        end else begin
            state_addr <= next_addr;
            first      <= 1'b0;
            if (stk_err_pulse) stack_err <= 1'b1;
        end
    end

`ifdef MICROSEQ_WAIT_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wait_cnt     <= '0;
            wait_timeout <= 1'b0;
        end else begin
            if (stall_int) wait_cnt <= wait_cnt + 1'b1;
            else           wait_cnt <= '0;
            if (timeout_hit) wait_timeout <= 1'b1;
        end
    end
    assign bus.wait_timeout = wait_timeout;
`endif

    assign bus.state_addr = state_addr;
    assign bus.stall      = stall_int;
    assign bus.cr_load    = !stall_int && !first;
    assign bus.stack_err  = stack_err;

    logic unused_full;
    assign unused_full = stk_full;

endmodule

// File: tb/tb_microsequencer_ctrl.sv
// Directed and randomized checks of microsequencer_ctrl against a queue-based model.
// Timeout scenario runs only when MICROSEQ_WAIT_TIMEOUT_EN is defined.
module tb_microsequencer_ctrl;
    localparam int         AW    = 8;
    localparam logic [7:0] RVEC  = 8'h00;
    localparam int         DEPTH = 2;
`ifdef MICROSEQ_WAIT_TIMEOUT_EN
    localparam int         TO    = 4;
    localparam logic [7:0] FVEC  = 8'hFF;
`endif

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    microsequencer_ctrl_if #(.ADDR_W(AW)) bus ();

`ifdef MICROSEQ_WAIT_TIMEOUT_EN
    microsequencer_ctrl #(.ADDR_W(AW), .RESET_VEC(RVEC), .STACK_DEPTH(DEPTH),
                          .WAIT_TIMEOUT(TO), .FAULT_VEC(FVEC))
        dut (.CLK(CLK), .RESET(RESET), .bus(bus));
`else
    microsequencer_ctrl #(.ADDR_W(AW), .RESET_VEC(RVEC), .STACK_DEPTH(DEPTH))
        dut (.CLK(CLK), .RESET(RESET), .bus(bus));
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_addr;
    logic       m_first;
    logic       m_err;
    logic [7:0] m_stack[$];
    int         m_wcnt;
    logic       m_wto;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr  = int'(RVEC);
        m_first = 1'b1;
        m_err   = 1'b0;
        m_stack.delete();
        m_wcnt  = 0;
        m_wto   = 1'b0;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic [2:0] ns, input logic [1:0] cs, input logic iv,
                        input logic [7:0] cr, input logic [7:0] dec,
                        input logic m, input logic c, input logic q);
        logic t, raw, to, e_stall;
        int   inc, nxt;
        bus.ns_sel = ns; bus.cond_sel = cs; bus.inv = iv; bus.cr_addr = cr;
        bus.dec_addr = dec; bus.moc = m; bus.cond_true = c; bus.irq = q;
        #1;
        case (cs)
            2'd0: t = m;
            2'd1: t = c;
            2'd2: t = 1'b1;
            default: t = q;
        endcase
        t   = t ^ iv;
        inc = (m_addr + 1) % 256;
        raw = (ns == 3'd4) && !t;
        to  = 1'b0;
`ifdef MICROSEQ_WAIT_TIMEOUT_EN
        if (raw && m_wcnt == TO) to = 1'b1;
`endif
        e_stall = raw && !to;
        chk("stall", bus.stall, e_stall);
        chk("cr_load", bus.cr_load, !e_stall && !m_first);
        nxt = m_addr;
        case (ns)
            3'd0: nxt = inc;
            3'd1: nxt = cr;
            3'd2: nxt = t ? cr : inc;
            3'd3: nxt = dec;
            3'd4: nxt = t ? inc : m_addr;
            3'd5: begin
                if (m_stack.size() == DEPTH) begin
                    void'(m_stack.pop_front());
                    m_err = 1'b1;
                end
                m_stack.push_back(8'(inc));
                nxt = cr;
            end
            3'd6: begin
                if (m_stack.size() == 0) begin
                    nxt   = int'(RVEC);
                    m_err = 1'b1;
                end else begin
                    nxt = m_stack.pop_back();
                end
            end
            default: begin
                nxt = int'(RVEC);
                m_stack.delete();
            end
        endcase
`ifdef MICROSEQ_WAIT_TIMEOUT_EN
        if (to) nxt = int'(FVEC);
`endif
        @(posedge CLK); #1;
        m_addr  = nxt;
        m_first = 1'b0;
        if (to) begin
            m_wcnt = 0;
            m_wto  = 1'b1;
        end else if (raw) m_wcnt++;
        else m_wcnt = 0;
        chk("state_addr", bus.state_addr, m_addr);
        chk("stack_err", bus.stack_err, m_err);
`ifdef MICROSEQ_WAIT_TIMEOUT_EN
        chk("wait_timeout", bus.wait_timeout, m_wto);
`endif
        @(negedge CLK);
    endtask

    task automatic op(input logic [2:0] ns, input logic [7:0] cr);
        step(ns, 2'd2, 1'b0, cr, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle, released at a negedge.
    task automatic do_reset();
        #2;
        RESET = 1'b0;
        #1;
        model_reset();
        chk("rst_state_addr", bus.state_addr, RVEC);
        chk("rst_cr_load", bus.cr_load, 1'b0);
        chk("rst_stack_err", bus.stack_err, 1'b0);
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0;
        bus.ns_sel = 3'd0; bus.cond_sel = 2'd0; bus.inv = 1'b0; bus.cr_addr = '0;
        bus.dec_addr = '0; bus.moc = 1'b0; bus.cond_true = 1'b0; bus.irq = 1'b0;
        model_reset();
        @(negedge CLK); @(negedge CLK);
        chk("reset_addr", bus.state_addr, RVEC);
        chk("reset_cr_load", bus.cr_load, 1'b0);
        chk("reset_err", bus.stack_err, 1'b0);
        RESET = 1'b1;

        // NEXT x3 from reset
        op(3'd0, 8'h00); op(3'd0, 8'h00); op(3'd0, 8'h00);
        chk("next_seq", bus.state_addr, 8'h03);

        // CJUMP on cond_true, both polarities of inv
        step(3'd2, 2'd1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("cjump_taken", bus.state_addr, 8'h40);
        step(3'd2, 2'd1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("cjump_not_taken", bus.state_addr, 8'h41);
        step(3'd2, 2'd1, 1'b1, 8'h40, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("cjump_inv_not_taken", bus.state_addr, 8'h42);
        step(3'd2, 2'd1, 1'b1, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("cjump_inv_taken", bus.state_addr, 8'h40);

        // WAIT at 0x10 on moc
        op(3'd1, 8'h10);
`ifdef MICROSEQ_WAIT_TIMEOUT_EN
        for (int i = 0; i < TO; i++) step(3'd4, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
`else
        for (int i = 0; i < 5; i++) step(3'd4, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
`endif
        chk("wait_hold", bus.state_addr, 8'h10);
        step(3'd4, 2'd0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("wait_release", bus.state_addr, 8'h11);

        // CALL/RET, then RET on empty stack
        op(3'd1, 8'h20);
        op(3'd5, 8'h80);
        chk("call_target", bus.state_addr, 8'h80);
        op(3'd6, 8'h00);
        chk("ret_addr", bus.state_addr, 8'h21);
        op(3'd6, 8'h00);
        chk("ret_empty_addr", bus.state_addr, RVEC);
        chk("ret_empty_err", bus.stack_err, 1'b1);

        // Overflow: three CALLs, two RETs
        do_reset();
        op(3'd1, 8'h30);
        op(3'd5, 8'h50);
        op(3'd5, 8'h60);
        op(3'd5, 8'h70);
        chk("overflow_err", bus.stack_err, 1'b1);
        op(3'd6, 8'h00);
        chk("ovf_ret1", bus.state_addr, 8'h61);
        op(3'd6, 8'h00);
        chk("ovf_ret2", bus.state_addr, 8'h51);

        // Wrap, DECODE, RST
        op(3'd1, 8'hFF);
        op(3'd0, 8'h00);
        chk("inc_wrap", bus.state_addr, 8'h00);
        step(3'd3, 2'd0, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("decode", bus.state_addr, 8'hA5);
        op(3'd5, 8'h33);
        op(3'd7, 8'h00);
        chk("rst_action", bus.state_addr, RVEC);

        // Reset in the middle of a WAIT with a live stack entry
        do_reset();
        op(3'd5, 8'h44);
        step(3'd4, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        step(3'd4, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        do_reset();
        op(3'd6, 8'h00);
        chk("ret_after_reset", bus.state_addr, RVEC);

`ifdef MICROSEQ_WAIT_TIMEOUT_EN
        do_reset();
        op(3'd1, 8'h10);
        for (int i = 0; i <= TO; i++) step(3'd4, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("timeout_addr", bus.state_addr, FVEC);
        chk("timeout_flag", bus.wait_timeout, 1'b1);
`endif

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            step(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
